m68k_wb_master: RTL

- Bus initiator that converts 68000-style CPU bus cycles into 32-bit Wishbone classic single cycles.
- Accepts 16-bit, big-endian, halfword-addressed requests with byte strobes and returns DTACK/BERR.
- Sits between the CPU core and the Wishbone interconnect, and drives slaves such as the SRAM interface.
- CPU-side inputs are already synchronous to wb_clk_i; no synchronisers are included.

---
 rtl/m68k_wb_master_if.sv | 23 ++
 rtl/m68k_wb_master.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/m68k_wb_master_if.sv
// Wishbone classic bus bundle between the 68000 bridge (master) and a slave.
interface m68k_wb_master_if #(
    parameter int AWIDTH = 24
);
    logic [AWIDTH-1:0] wb_addr_o;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_ack_i;

    modport master (
        output wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/m68k_wb_master.sv
// 68000 bus cycle to 32-bit Wishbone classic single-cycle bridge.
// Define M68K_WB_TIMEOUT_EN to enable the ack timeout that raises BERR.
module m68k_wb_master #(
    parameter int AWIDTH  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [AWIDTH-1:1] cpu_addr_i,
    input  logic              cpu_as_n_i,
    input  logic              cpu_uds_n_i,
    input  logic              cpu_lds_n_i,
    input  logic              cpu_rw_i,
    input  logic [15:0]       cpu_dat_i,
    output logic [15:0]       cpu_dat_o,
    output logic              cpu_dtack_n_o,
    output logic              cpu_berr_n_o,
    m68k_wb_master_if.master  wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reject a timeout the 8-bit counter cannot represent.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("m68k_wb_master: TIMEOUT must be in 1..255");
    end

    state_t            state_r,   state_s;
    logic [AWIDTH-1:0] addr_r,    addr_s;
    logic [31:0]       dat_o_r,   dat_o_s;
    logic [3:0]        sel_r,     sel_s;
    logic              we_r,      we_s;
    logic              cyc_r,     cyc_s;
    logic              a1_r,      a1_s;
    logic [15:0]       cpu_dat_r, cpu_dat_s;
    logic              dtack_n_r, dtack_n_s;
    logic              berr_n_r,  berr_n_s;
    logic              start_s;
    logic [15:0]       rd_half_s;
`ifdef M68K_WB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0]        cnt_r,     cnt_s;
`endif

    assign start_s   = !cpu_as_n_i && (!cpu_uds_n_i || !cpu_lds_n_i);
    assign rd_half_s = a1_r ? wb.wb_dat_i[15:0] : wb.wb_dat_i[31:16];

    // Next-state and next-output decode for the bus FSM.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        dat_o_s   = dat_o_r;
        sel_s     = sel_r;
        we_s      = we_r;
        cyc_s     = cyc_r;
        a1_s      = a1_r;
        cpu_dat_s = cpu_dat_r;
        dtack_n_s = dtack_n_r;
        berr_n_s  = berr_n_r;
`ifdef M68K_WB_TIMEOUT_EN
        cnt_s     = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // AS alone (write data-strobe delay) does not start a cycle.
                if (start_s) begin
                    addr_s  = {cpu_addr_i[AWIDTH-1:2], 2'b00};
                    we_s    = ~cpu_rw_i;
                    dat_o_s = {cpu_dat_i, cpu_dat_i};
                    a1_s    = cpu_addr_i[1];
                    if (cpu_addr_i[1]) begin
                        sel_s = {2'b00, ~cpu_uds_n_i, ~cpu_lds_n_i};
                    end else begin
                        sel_s = {~cpu_uds_n_i, ~cpu_lds_n_i, 2'b00};
                    end
                    cyc_s   = 1'b1;
`ifdef M68K_WB_TIMEOUT_EN
                    cnt_s   = 8'd0;
`endif
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (wb.wb_ack_i) begin
                    cyc_s = 1'b0;
                    sel_s = 4'b0000;
                    if (!we_r) begin
                        cpu_dat_s = rd_half_s;
                    end else begin
                        cpu_dat_s = cpu_dat_r;
                    end
                    // An abandoned cycle still finishes on the bus but never DTACKs.
                    if (!cpu_as_n_i) begin
                        dtack_n_s = 1'b0;
                        state_s   = ST_DONE;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end else begin
`ifdef M68K_WB_TIMEOUT_EN
                    cnt_s = cnt_r + 8'd1;
                    if (cnt_s == TIMEOUT_C) begin
                        cyc_s = 1'b0;
                        sel_s = 4'b0000;
                        if (!cpu_as_n_i) begin
                            berr_n_s = 1'b0;
                            state_s  = ST_DONE;
                        end else begin
                            state_s  = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_REQ;
                    end
`else
                    state_s = ST_REQ;
`endif
                end
            end
            ST_DONE: begin
                if (cpu_as_n_i) begin
                    dtack_n_s = 1'b1;
                    berr_n_s  = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_DONE;
                end
            end
            default: begin
                cyc_s     = 1'b0;
                sel_s     = 4'b0000;
                dtack_n_s = 1'b1;
                berr_n_s  = 1'b1;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            addr_r    <= {AWIDTH{1'b0}};
            dat_o_r   <= 32'h0000_0000;
            sel_r     <= 4'b0000;
            we_r      <= 1'b0;
            cyc_r     <= 1'b0;
            a1_r      <= 1'b0;
            cpu_dat_r <= 16'h0000;
            dtack_n_r <= 1'b1;
            berr_n_r  <= 1'b1;
`ifdef M68K_WB_TIMEOUT_EN
            cnt_r     <= 8'd0;
`endif
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            dat_o_r   <= dat_o_s;
            sel_r     <= sel_s;
            we_r      <= we_s;
            cyc_r     <= cyc_s;
            a1_r      <= a1_s;
            cpu_dat_r <= cpu_dat_s;
            dtack_n_r <= dtack_n_s;
            berr_n_r  <= berr_n_s;
`ifdef M68K_WB_TIMEOUT_EN
            cnt_r     <= cnt_s;
`endif
        end
    end

    assign wb.wb_addr_o  = addr_r;
    assign wb.wb_dat_o   = dat_o_r;
    assign wb.wb_sel_o   = sel_r;
    assign wb.wb_we_o    = we_r;
    assign wb.wb_cyc_o   = cyc_r;
    assign wb.wb_stb_o   = cyc_r;
    assign cpu_dat_o     = cpu_dat_r;
    assign cpu_dtack_n_o = dtack_n_r;
    assign cpu_berr_n_o  = berr_n_r;

endmodule
